sram_axi_bridge: RTL and testbench

Converts the core's two sram-like ports (64-bit instruction fetch, 32-bit data access) into a single AXI4 master, serialising requests and stalling the pipeline until each completes. Sits directly downstream of the address-translated sram ports of the CPU top and upstream of the SoC AXI interconnect. Only one transaction is outstanding at a time. Data requests take priority over instruction requests.

---
 rtl/sram_axi_bridge_pkg.sv | 54 +++++
 rtl/sram_axi_bridge_if.sv | 71 +++++++
 rtl/sram_axi_bridge.sv | 171 +++++++++++++++++
 tb/tb_sram_axi_bridge.sv | 324 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sram_axi_bridge_pkg.sv
// Shared types and constants for the sram-to-AXI4 bridge.
// Holds the FSM encoding, AXI burst/size/ID constants and AR payload helpers.
package sram_axi_bridge_pkg;

    localparam int unsigned ID_W   = 4;
    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;
    localparam int unsigned LEN_W  = 8;

    localparam logic [1:0]      BURST_INCR = 2'b01;
    localparam logic [2:0]      SIZE_4     = 3'b010;
    localparam logic [ID_W-1:0] INST_ID    = ID_W'(0);
    localparam logic [ID_W-1:0] DATA_ID    = ID_W'(1);

    typedef enum logic [3:0] {
        IDLE, D_AR, D_R, D_AW, D_W, D_B, I_AR, I_R, DONE
    } state_e;

    typedef struct packed {
        logic [ID_W-1:0]   id;
        logic [ADDR_W-1:0] addr;
        logic [LEN_W-1:0]  len;
    } ar_req_t;

    typedef struct packed {
        logic [ADDR_W-1:0] addr;
        logic [DATA_W-1:0] wdata;
        logic [STRB_W-1:0] wen;
    } data_req_t;

    function automatic logic [ADDR_W-1:0] word_align(input logic [ADDR_W-1:0] addr);
        return addr & ~ADDR_W'(3);
    endfunction

    // Single-beat word read for a load.
    function automatic ar_req_t data_ar(input logic [ADDR_W-1:0] addr);
        ar_req_t r;
        r.id   = DATA_ID;
        r.addr = word_align(addr);
        r.len  = LEN_W'(0);
        return r;
    endfunction

    // Two-beat read covering the 64-bit aligned fetch pair.
    function automatic ar_req_t inst_ar(input logic [ADDR_W-1:0] addr);
        ar_req_t r;
        r.id   = INST_ID;
        r.addr = addr & ~ADDR_W'(7);
        r.len  = LEN_W'(1);
        return r;
    endfunction

endpackage

// File: rtl/sram_axi_bridge_if.sv
// AXI4 master bus between the bridge and the SoC interconnect.
interface sram_axi_bridge_if;
    import sram_axi_bridge_pkg::*;

    logic [ID_W-1:0]   arid;
    logic [ADDR_W-1:0] araddr;
    logic [LEN_W-1:0]  arlen;
    logic [2:0]        arsize;
    logic [1:0]        arburst;
    logic              arlock;
    logic [3:0]        arcache;
    logic [2:0]        arprot;
    logic              arvalid;
    logic              arready;

    logic [ID_W-1:0]   rid;
    logic [DATA_W-1:0] rdata;
    logic [1:0]        rresp;
    logic              rlast;
    logic              rvalid;
    logic              rready;

    logic [ID_W-1:0]   awid;
    logic [ADDR_W-1:0] awaddr;
    logic [LEN_W-1:0]  awlen;
    logic [2:0]        awsize;
    logic [1:0]        awburst;
    logic              awlock;
    logic [3:0]        awcache;
    logic [2:0]        awprot;
    logic              awvalid;
    logic              awready;

    logic [DATA_W-1:0] wdata;
    logic [STRB_W-1:0] wstrb;
    logic              wlast;
    logic              wvalid;
    logic              wready;

    logic [ID_W-1:0]   bid;
    logic [1:0]        bresp;
    logic              bvalid;
    logic              bready;

    modport master (
        output arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        input  arready,
        input  rid, rdata, rresp, rlast, rvalid,
        output rready,
        output awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        input  awready,
        output wdata, wstrb, wlast, wvalid,
        input  wready,
        input  bid, bresp, bvalid,
        output bready
    );

    modport slave (
        input  arid, araddr, arlen, arsize, arburst, arlock, arcache, arprot, arvalid,
        output arready,
        output rid, rdata, rresp, rlast, rvalid,
        input  rready,
        input  awid, awaddr, awlen, awsize, awburst, awlock, awcache, awprot, awvalid,
        output awready,
        input  wdata, wstrb, wlast, wvalid,
        output wready,
        output bid, bresp, bvalid,
        input  bready
    );

endinterface

// File: rtl/sram_axi_bridge.sv
// Serialises the core's fetch and data sram ports onto one AXI4 master,
// one transaction at a time, data before instruction, stalling the core meanwhile.
module sram_axi_bridge
    import sram_axi_bridge_pkg::*;
(
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  inst_sram_en,
    input  logic [ADDR_W-1:0]     inst_sram_addr,
    output logic [2*DATA_W-1:0]   inst_sram_rdata,
    input  logic                  data_sram_en,
    input  logic [STRB_W-1:0]     data_sram_wen,
    input  logic [ADDR_W-1:0]     data_sram_addr,
    input  logic [DATA_W-1:0]     data_sram_wdata,
    output logic [DATA_W-1:0]     data_sram_rdata,
    output logic                  stallreq,
    sram_axi_bridge_if.master     axi
);

    state_e            state;
    logic              i_pend;
    logic              d_pend;
    logic [ADDR_W-1:0] inst_addr_q;
    data_req_t         dreq_q;
    ar_req_t           ar_q;
    logic              arvalid_q;
    logic              awvalid_q;
    logic              wvalid_q;
    logic              rready_q;
    logic              bready_q;

    // Stall must rise in the request cycle itself, hence combinational.
    assign stallreq = ((state == IDLE) && (inst_sram_en || data_sram_en))
                    || ((state != IDLE) && (state != DONE));

    assign axi.arid    = ar_q.id;
    assign axi.araddr  = ar_q.addr;
    assign axi.arlen   = ar_q.len;
    assign axi.arsize  = SIZE_4;
    assign axi.arburst = BURST_INCR;
    assign axi.arlock  = 1'b0;
    assign axi.arcache = 4'd0;
    assign axi.arprot  = 3'd0;
    assign axi.arvalid = arvalid_q;
    assign axi.rready  = rready_q;

    assign axi.awid    = DATA_ID;
    assign axi.awaddr  = word_align(dreq_q.addr);
    assign axi.awlen   = LEN_W'(0);
    assign axi.awsize  = SIZE_4;
    assign axi.awburst = BURST_INCR;
    assign axi.awlock  = 1'b0;
    assign axi.awcache = 4'd0;
    assign axi.awprot  = 3'd0;
    assign axi.awvalid = awvalid_q;
    assign axi.wdata   = dreq_q.wdata;
    assign axi.wstrb   = dreq_q.wen;
    assign axi.wlast   = 1'b1;
    assign axi.wvalid  = wvalid_q;
    assign axi.bready  = bready_q;

    // Responses and IDs are not checked; d_pend is kept for debug visibility.
    logic unused_resp;
    assign unused_resp = ^{axi.rid, axi.rresp, axi.bid, axi.bresp, d_pend};

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state           <= IDLE;
            i_pend          <= 1'b0;
            d_pend          <= 1'b0;
            inst_addr_q     <= '0;
            dreq_q          <= '0;
            ar_q            <= '0;
            arvalid_q       <= 1'b0;
            awvalid_q       <= 1'b0;
            wvalid_q        <= 1'b0;
            rready_q        <= 1'b0;
            bready_q        <= 1'b0;
            inst_sram_rdata <= '0;
            data_sram_rdata <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (inst_sram_en || data_sram_en) begin
                        i_pend      <= inst_sram_en;
                        d_pend      <= data_sram_en;
                        inst_addr_q <= inst_sram_addr;
                        dreq_q      <= '{addr: data_sram_addr, wdata: data_sram_wdata,
                                         wen: data_sram_wen};
                        if (data_sram_en && (data_sram_wen == '0)) begin
                            ar_q      <= data_ar(data_sram_addr);
                            arvalid_q <= 1'b1;
                            state     <= D_AR;
                        end else if (data_sram_en) begin
                            awvalid_q <= 1'b1;
                            state     <= D_AW;
                        end else begin
                            ar_q      <= inst_ar(inst_sram_addr);
                            arvalid_q <= 1'b1;
                            state     <= I_AR;
                        end
                    end
                end
                D_AR, I_AR: begin
                    if (axi.arready) begin
                        arvalid_q <= 1'b0;
                        rready_q  <= 1'b1;
                        state     <= (state == D_AR) ? D_R : I_R;
                    end
                end
                D_R: begin
                    if (axi.rvalid) begin
                        data_sram_rdata <= axi.rdata;
                        rready_q        <= 1'b0;
                        d_pend          <= 1'b0;
                        if (i_pend) begin
                            ar_q      <= inst_ar(inst_addr_q);
                            arvalid_q <= 1'b1;
                            state     <= I_AR;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                D_AW: begin
                    if (axi.awready) begin
                        awvalid_q <= 1'b0;
                        wvalid_q  <= 1'b1;
                        state     <= D_W;
                    end
                end
                D_W: begin
                    if (axi.wready) begin
                        wvalid_q <= 1'b0;
                        bready_q <= 1'b1;
                        state    <= D_B;
                    end
                end
                D_B: begin
                    if (axi.bvalid) begin
                        bready_q <= 1'b0;
                        d_pend   <= 1'b0;
                        if (i_pend) begin
                            ar_q      <= inst_ar(inst_addr_q);
                            arvalid_q <= 1'b1;
                            state     <= I_AR;
                        end else begin
                            state <= DONE;
                        end
                    end
                end
                I_R: begin
                    // Low word arrives first; the rlast beat completes the pair.
                    if (axi.rvalid) begin
                        if (axi.rlast) begin
                            inst_sram_rdata[2*DATA_W-1:DATA_W] <= axi.rdata;
                            rready_q <= 1'b0;
                            i_pend   <= 1'b0;
                            state    <= DONE;
                        end else begin
                            inst_sram_rdata[DATA_W-1:0] <= axi.rdata;
                        end
                    end
                end
                DONE:    state <= IDLE;
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sram_axi_bridge.sv
// Directed bench for sram_axi_bridge with a small AXI slave model and
// hand-computed expectations; inputs driven and outputs sampled on negedge.
module tb_sram_axi_bridge;
    import sram_axi_bridge_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic        inst_sram_en;
    logic [31:0] inst_sram_addr;
    logic [63:0] inst_sram_rdata;
    logic        data_sram_en;
    logic [3:0]  data_sram_wen;
    logic [31:0] data_sram_addr;
    logic [31:0] data_sram_wdata;
    logic [31:0] data_sram_rdata;
    logic        stallreq;

    always #5 clk = ~clk;

    sram_axi_bridge_if bus ();

    sram_axi_bridge dut (
        .clk             (clk),
        .rst             (rst),
        .inst_sram_en    (inst_sram_en),
        .inst_sram_addr  (inst_sram_addr),
        .inst_sram_rdata (inst_sram_rdata),
        .data_sram_en    (data_sram_en),
        .data_sram_wen   (data_sram_wen),
        .data_sram_addr  (data_sram_addr),
        .data_sram_wdata (data_sram_wdata),
        .data_sram_rdata (data_sram_rdata),
        .stallreq        (stallreq),
        .axi             (bus.slave)
    );

    // Slave configuration and logs
    int          ar_delay = 0;
    int          ar_cnt;
    logic        w_hold = 1'b0;
    logic [1:0]  rresp_cfg = 2'b00;
    logic [31:0] r_addr;
    int          r_left;
    logic [3:0]  ar_id_log[$];
    logic [31:0] ar_addr_log[$];
    logic [7:0]  ar_len_log[$];
    logic [31:0] aw_addr_log[$];
    logic [3:0]  aw_id_log[$];
    logic [31:0] w_data_log[$];
    logic [3:0]  w_strb_log[$];
    logic        w_last_log[$];
    int          ar_wait;
    logic        ar_wrong;
    logic [31:0] ar_expect;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        if (a == 32'hBFC0_0000) return 32'h1111_1111;
        if (a == 32'hBFC0_0004) return 32'h2222_2222;
        return a ^ 32'h5A5A_5A5A;
    endfunction

    assign bus.arready = bus.arvalid && (ar_cnt >= ar_delay);
    assign bus.awready = bus.awvalid;
    assign bus.wready  = bus.wvalid && !w_hold;

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            ar_cnt     <= 0;
            r_addr     <= '0;
            r_left     <= 0;
            bus.rvalid <= 1'b0;
            bus.rlast  <= 1'b0;
            bus.rdata  <= '0;
            bus.rid    <= '0;
            bus.rresp  <= '0;
            bus.bvalid <= 1'b0;
            bus.bid    <= '0;
            bus.bresp  <= '0;
        end else begin
            if (bus.arvalid && !bus.arready) ar_cnt <= ar_cnt + 1;
            if (bus.arvalid && bus.arready) begin
                ar_cnt     <= 0;
                ar_id_log.push_back(bus.arid);
                ar_addr_log.push_back(bus.araddr);
                ar_len_log.push_back(bus.arlen);
                bus.rvalid <= 1'b1;
                bus.rdata  <= mem_word(bus.araddr);
                bus.rlast  <= (bus.arlen == 8'd0);
                bus.rid    <= bus.arid;
                bus.rresp  <= rresp_cfg;
                r_addr     <= bus.araddr + 32'd4;
                r_left     <= int'(bus.arlen);
            end else if (bus.rvalid && bus.rready) begin
                if (r_left == 0) begin
                    bus.rvalid <= 1'b0;
                    bus.rlast  <= 1'b0;
                end else begin
                    bus.rdata <= mem_word(r_addr);
                    bus.rlast <= (r_left == 1);
                    r_addr    <= r_addr + 32'd4;
                    r_left    <= r_left - 1;
                end
            end
            if (bus.awvalid && bus.awready) begin
                aw_addr_log.push_back(bus.awaddr);
                aw_id_log.push_back(bus.awid);
            end
            if (bus.wvalid && bus.wready) begin
                w_data_log.push_back(bus.wdata);
                w_strb_log.push_back(bus.wstrb);
                w_last_log.push_back(bus.wlast);
                bus.bvalid <= 1'b1;
                bus.bid    <= 4'd1;
            end else if (bus.bvalid && bus.bready) begin
                bus.bvalid <= 1'b0;
            end
        end
    end

    // AR wait-state monitor: count stalled cycles and flag any address wobble.
    always @(negedge clk) begin
        if (bus.arvalid && !bus.arready) begin
            ar_wait = ar_wait + 1;
            if (bus.araddr !== ar_expect) ar_wrong = 1'b1;
        end
    end

    int total = 0;
    int bad   = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic clear_logs();
        ar_id_log.delete(); ar_addr_log.delete(); ar_len_log.delete();
        aw_addr_log.delete(); aw_id_log.delete();
        w_data_log.delete(); w_strb_log.delete(); w_last_log.delete();
        ar_wait = 0; ar_wrong = 1'b0;
    endtask

    // Called on a negedge; returns on the negedge where stall has dropped (DONE).
    task automatic run_req(input logic ie, input logic [31:0] ia, input logic de,
                           input logic [3:0] dw, input logic [31:0] da, input logic [31:0] dd,
                           output int stalls, output logic timed_out);
        inst_sram_en = ie; inst_sram_addr = ia;
        data_sram_en = de; data_sram_wen = dw; data_sram_addr = da; data_sram_wdata = dd;
        #1;
        stalls    = stallreq ? 1 : 0;
        timed_out = 1'b1;
        for (int i = 0; i < 64; i++) begin
            @(negedge clk);
            if (!stallreq) begin
                timed_out = 1'b0;
                break;
            end
            stalls++;
        end
    endtask

    task automatic release_req();
        inst_sram_en = 1'b0;
        data_sram_en = 1'b0;
    endtask

    initial begin
        int   stalls;
        logic to;
        logic seen;

        rst = 1'b1;
        inst_sram_en = 1'b0; inst_sram_addr = '0;
        data_sram_en = 1'b0; data_sram_wen = '0; data_sram_addr = '0; data_sram_wdata = '0;
        clear_logs();
        ar_expect = '0;
        repeat (2) @(negedge clk);

        // Reset state
        check("rst_stall",   64'(stallreq), 64'd0);
        check("rst_arvalid", 64'(bus.arvalid), 64'd0);
        check("rst_awvalid", 64'(bus.awvalid), 64'd0);
        check("rst_wvalid",  64'(bus.wvalid), 64'd0);
        check("rst_rready",  64'(bus.rready), 64'd0);
        check("rst_bready",  64'(bus.bready), 64'd0);
        check("rst_irdata",  inst_sram_rdata, 64'd0);
        check("rst_drdata",  64'(data_sram_rdata), 64'd0);
        check("rst_arcache", 64'({bus.arlock, bus.arcache, bus.arprot}), 64'd0);
        inst_sram_en = 1'b1;
        #1 check("rst_stall_eq", 64'(stallreq), 64'd1);
        inst_sram_en = 1'b0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);

        // Fetch from zero-wait slave
        clear_logs();
        run_req(1'b1, 32'hBFC0_0004, 1'b0, 4'h0, 32'h0, 32'h0, stalls, to);
        check("fetch_to",     64'(to), 64'd0);
        check("fetch_stalls", 64'(stalls), 64'd4);
        check("fetch_rdata",  inst_sram_rdata, 64'h2222_2222_1111_1111);
        check("fetch_ar_n",   64'(ar_addr_log.size()), 64'd1);
        check("fetch_araddr", 64'(ar_addr_log[0]), 64'hBFC0_0000);
        check("fetch_arlen",  64'(ar_len_log[0]), 64'd1);
        check("fetch_arid",   64'(ar_id_log[0]), 64'd0);
        check("arsize",       64'({bus.arsize, bus.arburst}), 64'({3'b010, 2'b01}));
        release_req();
        @(negedge clk);
        check("fetch_idle",   64'(stallreq), 64'd0);

        // Store with partial strobes
        clear_logs();
        run_req(1'b0, 32'h0, 1'b1, 4'b0011, 32'h8000_0012, 32'hAABB_CCDD, stalls, to);
        check("st_to",     64'(to), 64'd0);
        check("st_stalls", 64'(stalls), 64'd4);
        check("st_aw_n",   64'(aw_addr_log.size()), 64'd1);
        check("st_awaddr", 64'(aw_addr_log[0]), 64'h8000_0010);
        check("st_awid",   64'(aw_id_log[0]), 64'd1);
        check("st_wstrb",  64'(w_strb_log[0]), 64'b0011);
        check("st_wdata",  64'(w_data_log[0]), 64'hAABB_CCDD);
        check("st_wlast",  64'(w_last_log[0]), 64'd1);
        check("st_no_ar",  64'(ar_addr_log.size()), 64'd0);
        check("st_bready", 64'(bus.bready), 64'd0);
        release_req();
        @(negedge clk);

        // Simultaneous load and fetch: data first, one DONE
        clear_logs();
        run_req(1'b1, 32'h8000_0200, 1'b1, 4'h0, 32'h8000_0100, 32'h0, stalls, to);
        check("lf_to",      64'(to), 64'd0);
        check("lf_stalls",  64'(stalls), 64'd6);
        check("lf_ar_n",    64'(ar_addr_log.size()), 64'd2);
        check("lf_ar0_id",  64'(ar_id_log[0]), 64'd1);
        check("lf_ar0_adr", 64'(ar_addr_log[0]), 64'h8000_0100);
        check("lf_ar0_len", 64'(ar_len_log[0]), 64'd0);
        check("lf_ar1_id",  64'(ar_id_log[1]), 64'd0);
        check("lf_ar1_adr", 64'(ar_addr_log[1]), 64'h8000_0200);
        check("lf_drdata",  64'(data_sram_rdata), 64'hDA5A_5B5A);
        check("lf_irdata",  inst_sram_rdata, 64'hDA5A_585E_DA5A_585A);
        release_req();
        @(negedge clk);
        check("lf_one_done", 64'(stallreq), 64'd0);
        check("lf_quiet",    64'({bus.arvalid, bus.rready}), 64'd0);

        // Load with arready held low for 5 cycles
        clear_logs();
        ar_delay  = 5;
        ar_expect = 32'h8000_0040;
        run_req(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0040, 32'h0, stalls, to);
        check("arw_to",     64'(to), 64'd0);
        check("arw_stalls", 64'(stalls), 64'd8);
        check("arw_wait",   64'(ar_wait), 64'd5);
        check("arw_stable", 64'(ar_wrong), 64'd0);
        check("arw_ar_n",   64'(ar_addr_log.size()), 64'd1);
        check("arw_drdata", 64'(data_sram_rdata), 64'hDA5A_5A1A);
        release_req();
        ar_delay = 0;
        @(negedge clk);

        // SLVERR response is ignored
        clear_logs();
        rresp_cfg = 2'b10;
        run_req(1'b0, 32'h0, 1'b1, 4'h0, 32'h8000_0008, 32'h0, stalls, to);
        check("err_to",     64'(to), 64'd0);
        check("err_stalls", 64'(stalls), 64'd3);
        check("err_drdata", 64'(data_sram_rdata), 64'hDA5A_5A52);
        check("err_ihold",  inst_sram_rdata, 64'hDA5A_585E_DA5A_585A);
        release_req();
        rresp_cfg = 2'b00;
        @(negedge clk);
        check("err_idle",   64'(stallreq), 64'd0);

        // Reset asserted while waiting in D_W
        clear_logs();
        w_hold = 1'b1;
        inst_sram_en = 1'b0;
        data_sram_en = 1'b1; data_sram_wen = 4'hF;
        data_sram_addr = 32'h8000_0020; data_sram_wdata = 32'h1234_5678;
        seen = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            if (bus.wvalid) begin
                seen = 1'b1;
                break;
            end
        end
        check("rdw_reach_w", 64'(seen), 64'd1);
        rst = 1'b1;
        release_req();
        #1;
        check("rdw_wv_async", 64'(bus.wvalid), 64'd0);
        @(negedge clk);
        check("rdw_wvalid",  64'(bus.wvalid), 64'd0);
        check("rdw_valids",  64'({bus.arvalid, bus.awvalid, bus.bready, bus.rready}), 64'd0);
        check("rdw_stall",   64'(stallreq), 64'd0);
        check("rdw_irdata",  inst_sram_rdata, 64'd0);
        check("rdw_drdata",  64'(data_sram_rdata), 64'd0);
        rst = 1'b0;
        w_hold = 1'b0;
        @(negedge clk);

        // Normal fetch after the mid-transaction reset
        clear_logs();
        run_req(1'b1, 32'hBFC0_0004, 1'b0, 4'h0, 32'h0, 32'h0, stalls, to);
        check("post_to",     64'(to), 64'd0);
        check("post_stalls", 64'(stalls), 64'd4);
        check("post_rdata",  inst_sram_rdata, 64'h2222_2222_1111_1111);
        release_req();
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: observed=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
